// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store unit controller.
//
// Accepts one request at a time (IDLE), issues a single bus-aligned memory
// access with lane-shifted store data and byte enables (ACCESS), then returns
// a one-cycle completion with sign/zero-extended load data (RESP).
// Misaligned or illegal requests skip the memory and complete with resp_err.
// An access that sees no mem_ready for TIMEOUT cycles completes with resp_err.
//
// Ports
//   clk, reset             clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake (req_ready == state is IDLE)
//   req_we, req_type       1=store / 0=load; 000 w, 001 h, 010 hu, 011 b, 100 bu, 101 d
//   req_addr, req_wdata    byte address, right-justified store data
//   resp_valid/_rdata/_err one-cycle completion, extended load data, error flag
//   mem_en/_addr/_wdata/_wea  memory request, aligned address, shifted data, byte enables
//   mem_rdata, mem_ready   memory response
//   busy                   state is not IDLE
module lsu_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_type,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                mem_en,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wea,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready,
    output logic                busy
);

    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(LANES - 1));

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_q;
    logic [7:0]          cnt_q;
    logic                we_q;
    logic [2:0]          type_q;
    logic [OFF_W-1:0]    off_q;
    logic                resp_valid_q, resp_err_q, mem_en_q;
    logic [DATA_W-1:0]   resp_rdata_q, mem_wdata_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [LANES-1:0]    mem_wea_q;

    // Request decode (only consumed at the acceptance edge).
    logic [3:0]       size;
    logic             illegal, misal;
    logic [OFF_W-1:0] req_off;
    logic [LANES-1:0] size_mask;

    always_comb begin
        size    = 4'd4;
        illegal = 1'b0;
        case (req_type)
            3'b000:         size = 4'd4;
            3'b001, 3'b010: size = 4'd2;
            3'b011, 3'b100: size = 4'd1;
            3'b101: begin
                size    = 4'd8;
                illegal = (DATA_W == 32);
            end
            default:        illegal = 1'b1;
        endcase
        // size-1 wraps to 3'b111 for dword, giving the 8-byte alignment mask.
        misal   = (req_addr[2:0] & (size[2:0] - 3'd1)) != 3'd0;
        req_off = req_addr[OFF_W-1:0];
        for (int i = 0; i < LANES; i++) size_mask[i] = (i < int'(size));
    end

    // Load data extraction from the lane selected by the latched offset.
    logic [DATA_W-1:0] sh, ext;

    always_comb begin
        sh = mem_rdata >> {off_q, 3'b000};
        case (type_q)
            3'b000:  ext = DATA_W'(signed'(sh[31:0]));
            3'b001:  ext = DATA_W'(signed'(sh[15:0]));
            3'b010:  ext = DATA_W'(sh[15:0]);
            3'b011:  ext = DATA_W'(signed'(sh[7:0]));
            3'b100:  ext = DATA_W'(sh[7:0]);
            default: ext = sh;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            type_q       <= '0;
            off_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_en_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wea_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    we_q   <= req_we;
                    type_q <= req_type;
                    off_q  <= req_off;
                    cnt_q  <= '0;
                    if (illegal || misal) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= '0;
                    end else begin
                        state_q     <= ACCESS;
                        mem_en_q    <= 1'b1;
                        mem_addr_q  <= req_addr & ALIGN_MASK;
                        mem_wdata_q <= req_wdata << {req_off, 3'b000};
                        mem_wea_q   <= req_we ? (size_mask << req_off) : '0;
                    end
                end
                ACCESS: begin
                    cnt_q <= cnt_q + 8'd1;
                    // mem_ready wins over a timeout landing on the same edge.
                    if (mem_ready || cnt_q == 8'(TIMEOUT - 1)) begin
                        state_q      <= RESP;
                        mem_en_q     <= 1'b0;
                        mem_wea_q    <= '0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= !mem_ready;
                        resp_rdata_q <= (mem_ready && !we_q) ? ext : '0;
                    end
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_en     = mem_en_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wea    = mem_wea_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: a 32-bit (TIMEOUT=4) and a 64-bit (TIMEOUT=6) instance
// share one stimulus stream; each is checked against an arithmetic model.
module tb_lsu_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req_valid, req_we, mem_ready;
    logic [2:0]  req_type;
    logic [31:0] req_addr;
    logic [63:0] req_wdata, mem_rdata;

    logic [1:0]  rdy, rv, re, men, bsy;
    logic [31:0] ma32, ma64, rd32, wd32;
    logic [3:0]  wea32;
    logic [63:0] rd64, wd64;
    logic [7:0]  wea64;

    lsu_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u32 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_we(req_we), .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .resp_valid(rv[0]), .resp_rdata(rd32), .resp_err(re[0]),
        .mem_en(men[0]), .mem_addr(ma32), .mem_wdata(wd32), .mem_wea(wea32),
        .mem_rdata(mem_rdata[31:0]), .mem_ready(mem_ready), .busy(bsy[0]));

    lsu_ctrl #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(6)) u64 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_we(req_we), .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv[1]), .resp_rdata(rd64), .resp_err(re[1]),
        .mem_en(men[1]), .mem_addr(ma64), .mem_wdata(wd64), .mem_wea(wea64),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(bsy[1]));

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [63:0] g_rd(int d);  return d ? rd64 : {32'b0, rd32};  endfunction
    function automatic logic [63:0] g_wd(int d);  return d ? wd64 : {32'b0, wd32};  endfunction
    function automatic logic [7:0]  g_wea(int d); return d ? wea64 : {4'b0, wea32}; endfunction
    function automatic logic [31:0] g_ad(int d);  return d ? ma64 : ma32;           endfunction
    function automatic int          g_w(int d);   return d ? 64 : 32;               endfunction
    function automatic int          g_t(int d);   return d ? 6 : 4;                 endfunction

    // Observations of the last transaction, per instance (0 = 32-bit, 1 = 64-bit).
    int          o_nresp[2], o_rcyc[2], o_encnt[2], o_bcnt[2];
    logic        o_rdy0[2], o_err[2], o_stable[2], o_clash[2];
    logic [63:0] o_rd[2], o_wd[2];
    logic [31:0] o_ad[2];
    logic [7:0]  o_wea[2];

    // Reference: expected outcome of one request given mem_ready is low for
    // the first 'delay' access cycles, then high.
    task automatic model(input int d, input logic we, input logic [2:0] typ,
                         input logic [31:0] addr, input logic [63:0] wdata, rdata,
                         input int delay, output logic err, output int en,
                         output logic [63:0] rd, output logic [31:0] ad,
                         output logic [63:0] wd, output logic [7:0] wea);
        int lanes, off, size;
        logic sgn;
        logic [63:0] m, v, wmask;
        lanes = g_w(d) / 8;
        off   = int'(addr % 32'(lanes));
        wmask = (g_w(d) == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        sgn   = 1'b0;
        case (typ)
            3'd0:    begin size = 4; sgn = 1'b1; end
            3'd1:    begin size = 2; sgn = 1'b1; end
            3'd2:    size = 2;
            3'd3:    begin size = 1; sgn = 1'b1; end
            3'd4:    size = 1;
            3'd5:    size = 8;
            default: size = 0;
        endcase
        err = (size == 0) || (size == 8 && g_w(d) == 32);
        if (size != 0 && (addr % 32'(size)) != 0) err = 1'b1;
        ad  = addr - 32'(off);
        m   = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : (64'd1 << (8 * size)) - 64'd1;
        v   = ((rdata & wmask) >> (8 * off)) & m;
        if (size != 0 && sgn && v[8*size-1]) v = v | ~m;
        rd  = v & wmask;
        wd  = (wdata << (8 * off)) & wmask;
        wea = we ? 8'(((1 << size) - 1) << off) : 8'h00;
        if (err) begin
            en = 0; rd = '0;
        end else if (delay <= g_t(d) - 1) begin
            en = delay + 1;
        end else begin
            en = g_t(d); err = 1'b1; rd = '0;
        end
        if (we) rd = '0;
    endtask

    // Drive one request, then observe 10 cycles (cycle 0 = first after acceptance).
    task automatic run_txn(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                           input logic [63:0] wdata, rdata, input int delay);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_type = typ; req_addr = addr; req_wdata = wdata;
        mem_ready = 1'b1; mem_rdata = {$urandom, $urandom};
        for (int d = 0; d < 2; d++) begin
            o_rdy0[d] = rdy[d]; o_nresp[d] = 0; o_rcyc[d] = -1; o_encnt[d] = 0; o_bcnt[d] = 0;
            o_err[d] = 1'b0; o_rd[d] = '0; o_stable[d] = 1'b1; o_clash[d] = 1'b0;
            o_ad[d] = '0; o_wd[d] = '0; o_wea[d] = '0;
        end
        @(posedge clk); #1;
        // Scramble the request inputs: the access must use the latched copy.
        req_valid = 1'b0; req_we = 1'($urandom); req_type = 3'($urandom);
        req_addr = $urandom; req_wdata = {$urandom, $urandom};
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (men[d]) begin
                    if (o_encnt[d] == 0) begin
                        o_ad[d] = g_ad(d); o_wd[d] = g_wd(d); o_wea[d] = g_wea(d);
                    end
                    o_encnt[d]++;
                end
                if (bsy[d]) o_bcnt[d]++;
                if (rdy[d] === bsy[d]) o_clash[d] = 1'b1;
                if (rv[d]) begin
                    o_nresp[d]++; o_rcyc[d] = j; o_err[d] = re[d]; o_rd[d] = g_rd(d);
                end else if (o_nresp[d] > 0 && g_rd(d) !== o_rd[d]) begin
                    o_stable[d] = 1'b0;
                end
            end
            mem_ready = (j >= delay);
            mem_rdata = mem_ready ? rdata : {$urandom, $urandom};
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_type = 3'd0;
        req_addr = 32'h100; req_wdata = '1; mem_ready = 1'b1; mem_rdata = '1;
        #3;
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if ({rv[d], re[d], men[d], bsy[d], rdy[d]} !== 5'b00001) begin
                n_err++; $display("FAIL reset_ctl[%0d]: got %b want 00001", d, {rv[d], re[d], men[d], bsy[d], rdy[d]});
            end
            n_vec++;
            if ({g_rd(d), g_wd(d), g_ad(d), g_wea(d)} !== '0) begin
                n_err++; $display("FAIL reset_data[%0d]: rd=%h wd=%h ad=%h wea=%h want 0", d, g_rd(d), g_wd(d), g_ad(d), g_wea(d));
            end
        end
        req_valid = 1'b0;
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_load_half();
        run_txn(1'b0, 3'b001, 32'h102, 64'h0, 64'h0000_0000_8001_1234, 0);
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (o_ad[d] !== 32'h100 || o_encnt[d] !== 1) begin
                n_err++; $display("FAIL lh_mem[%0d]: addr=%h en=%0d want 100/1", d, o_ad[d], o_encnt[d]);
            end
            n_vec++;
            if (o_rcyc[d] !== 1 || o_err[d] !== 1'b0 || o_nresp[d] !== 1) begin
                n_err++; $display("FAIL lh_resp[%0d]: cyc=%0d err=%b n=%0d want 1/0/1", d, o_rcyc[d], o_err[d], o_nresp[d]);
            end
        end
        n_vec++;
        if (o_rd[0] !== 64'h0000_0000_FFFF_8001) begin
            n_err++; $display("FAIL lh_data32: got %h want ffff8001", o_rd[0]);
        end
        n_vec++;
        if (o_rd[1] !== 64'hFFFF_FFFF_FFFF_8001) begin
            n_err++; $display("FAIL lh_data64: got %h want ffffffffffff8001", o_rd[1]);
        end
    endtask

    task automatic test_store_byte();
        run_txn(1'b1, 3'b011, 32'h203, 64'hAB, 64'hDEAD_BEEF_0123_4567, 0);
        n_vec++;
        if (o_wea[0] !== 8'b1000 || o_wd[0] !== 64'hAB00_0000 || o_ad[0] !== 32'h200) begin
            n_err++; $display("FAIL sb32: wea=%b wd=%h ad=%h want 1000/ab000000/200", o_wea[0], o_wd[0], o_ad[0]);
        end
        n_vec++;
        if (o_wea[1] !== 8'h08 || o_wd[1] !== 64'hAB00_0000 || o_ad[1] !== 32'h200) begin
            n_err++; $display("FAIL sb64: wea=%h wd=%h ad=%h want 08/ab000000/200", o_wea[1], o_wd[1], o_ad[1]);
        end
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (o_rd[d] !== '0 || o_err[d] !== 1'b0 || o_rcyc[d] !== 1) begin
                n_err++; $display("FAIL sb_resp[%0d]: rd=%h err=%b cyc=%0d want 0/0/1", d, o_rd[d], o_err[d], o_rcyc[d]);
            end
        end
    endtask

    task automatic test_errors();
        run_txn(1'b0, 3'b000, 32'h101, 64'h0, 64'h1111_2222_3333_4444, 0);
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (o_err[d] !== 1'b1 || o_rcyc[d] !== 0 || o_encnt[d] !== 0 || o_rd[d] !== '0) begin
                n_err++; $display("FAIL misal[%0d]: err=%b cyc=%0d en=%0d rd=%h want 1/0/0/0", d, o_err[d], o_rcyc[d], o_encnt[d], o_rd[d]);
            end
        end
        run_txn(1'b1, 3'b110, 32'h100, 64'h5, 64'h0, 0);
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (o_err[d] !== 1'b1 || o_encnt[d] !== 0 || o_nresp[d] !== 1) begin
                n_err++; $display("FAIL badtype[%0d]: err=%b en=%0d n=%0d want 1/0/1", d, o_err[d], o_encnt[d], o_nresp[d]);
            end
        end
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 3'b000, 32'h40, 64'h0, 64'h0, 100);
        n_vec++;
        if (o_encnt[0] !== 4 || o_rcyc[0] !== 4 || o_err[0] !== 1'b1) begin
            n_err++; $display("FAIL tmo32: en=%0d cyc=%0d err=%b want 4/4/1", o_encnt[0], o_rcyc[0], o_err[0]);
        end
        n_vec++;
        if (o_encnt[1] !== 6 || o_rcyc[1] !== 6 || o_err[1] !== 1'b1) begin
            n_err++; $display("FAIL tmo64: en=%0d cyc=%0d err=%b want 6/6/1", o_encnt[1], o_rcyc[1], o_err[1]);
        end
        // Ready on the 4th access cycle: coincides with the 32-bit timeout edge.
        run_txn(1'b0, 3'b000, 32'h40, 64'h0, 64'h0000_0000_CAFE_F00D, 3);
        n_vec++;
        if (o_encnt[0] !== 4 || o_err[0] !== 1'b0 || o_rd[0] !== 64'hCAFE_F00D) begin
            n_err++; $display("FAIL tmo_edge32: en=%0d err=%b rd=%h want 4/0/cafef00d", o_encnt[0], o_err[0], o_rd[0]);
        end
        n_vec++;
        if (o_encnt[1] !== 4 || o_err[1] !== 1'b0 || o_rd[1] !== 64'hFFFF_FFFF_CAFE_F00D) begin
            n_err++; $display("FAIL tmo_edge64: en=%0d err=%b rd=%h want 4/0/ffffffffcafef00d", o_encnt[1], o_err[1], o_rd[1]);
        end
    endtask

    task automatic test_wide();
        run_txn(1'b0, 3'b100, 32'h7, 64'h0, 64'hFE00_0000_0000_0000, 0);
        n_vec++;
        if (o_rd[1] !== 64'h0000_0000_0000_00FE || o_err[1] !== 1'b0) begin
            n_err++; $display("FAIL lbu64: rd=%h err=%b want fe/0", o_rd[1], o_err[1]);
        end
        run_txn(1'b0, 3'b101, 32'h8, 64'h0, 64'h0123_4567_89AB_CDEF, 1);
        n_vec++;
        if (o_err[0] !== 1'b1 || o_encnt[0] !== 0) begin
            n_err++; $display("FAIL dword32: err=%b en=%0d want 1/0", o_err[0], o_encnt[0]);
        end
        n_vec++;
        if (o_err[1] !== 1'b0 || o_rd[1] !== 64'h0123_4567_89AB_CDEF || o_encnt[1] !== 2) begin
            n_err++; $display("FAIL dword64: err=%b rd=%h en=%0d want 0/0123456789abcdef/2", o_err[1], o_rd[1], o_encnt[1]);
        end
    endtask

    task automatic test_random();
        logic        we, e_err;
        logic [2:0]  typ;
        logic [31:0] addr, e_ad;
        logic [63:0] wdata, rdata, e_rd, e_wd;
        logic [7:0]  e_wea;
        int          delay, e_en;
        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom); typ = 3'($urandom_range(0, 7)); addr = $urandom;
            if ($urandom_range(0, 1) == 0) addr[2:0] = 3'b000;
            wdata = {$urandom, $urandom}; rdata = {$urandom, $urandom};
            delay = $urandom_range(0, 7);
            run_txn(we, typ, addr, wdata, rdata, delay);
            for (int d = 0; d < 2; d++) begin
                model(d, we, typ, addr, wdata, rdata, delay, e_err, e_en, e_rd, e_ad, e_wd, e_wea);
                n_vec++;
                if (o_nresp[d] !== 1 || o_rcyc[d] !== e_en || o_err[d] !== e_err || o_rd[d] !== e_rd) begin
                    n_err++; $display("FAIL rnd_resp[%0d] #%0d: n=%0d cyc=%0d err=%b rd=%h want 1/%0d/%b/%h",
                                      d, n, o_nresp[d], o_rcyc[d], o_err[d], o_rd[d], e_en, e_err, e_rd);
                end
                n_vec++;
                if (o_encnt[d] !== e_en || o_bcnt[d] !== e_en + 1 || o_rdy0[d] !== 1'b1 || o_clash[d] || !o_stable[d]) begin
                    n_err++; $display("FAIL rnd_ctl[%0d] #%0d: en=%0d busy=%0d rdy=%b clash=%b stable=%b want %0d/%0d/1/0/1",
                                      d, n, o_encnt[d], o_bcnt[d], o_rdy0[d], o_clash[d], o_stable[d], e_en, e_en + 1);
                end
                if (e_en > 0) begin
                    n_vec++;
                    if (o_ad[d] !== e_ad || o_wea[d] !== e_wea || (we && o_wd[d] !== e_wd)) begin
                        n_err++; $display("FAIL rnd_mem[%0d] #%0d: ad=%h wea=%h wd=%h want %h/%h/%h",
                                          d, n, o_ad[d], o_wea[d], o_wd[d], e_ad, e_wea, e_wd);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int  cnt[2];
        logic bad[2];
        cnt = '{0, 0}; bad = '{1'b0, 1'b0};
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_type = 3'b000; req_addr = 32'h40;
        mem_ready = 1'b1; mem_rdata = 64'h0000_0000_0000_0055;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rv[d]) cnt[d]++;
                if (rv[d] !== (j % 3 == 1)) bad[d] = 1'b1;
            end
        end
        req_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (cnt[d] !== 4 || bad[d]) begin
                n_err++; $display("FAIL b2b[%0d]: resps=%0d pattern_bad=%b want 4/0", d, cnt[d], bad[d]);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_abort();
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_type = 3'b000; req_addr = 32'h80;
        req_wdata = 64'h1234; mem_ready = 1'b0;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        n_vec++;
        if (men !== 2'b11) begin
            n_err++; $display("FAIL abort_pre: mem_en=%b want 11", men);
        end
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if (men !== 2'b00 || rv !== 2'b00 || rdy !== 2'b11 || bsy !== 2'b00 || wea32 !== 4'h0 || wea64 !== 8'h0) begin
            n_err++; $display("FAIL abort_now: en=%b rv=%b rdy=%b busy=%b want 00/00/11/00", men, rv, rdy, bsy);
        end
        @(negedge clk); reset = 1'b1; mem_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (rv !== 2'b00 || men !== 2'b00) seen = 1'b1;
        end
        n_vec++;
        if (seen || rdy !== 2'b11) begin
            n_err++; $display("FAIL abort_post: stray=%b rdy=%b want 0/11", seen, rdy);
        end
    endtask

    initial begin
        test_reset();
        test_load_half();
        test_store_byte();
        test_errors();
        test_timeout();
        test_wide();
        test_back_to_back();
        test_random();
        test_abort();
        test_load_half();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data bus width; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum wait cycles for mem_ready; legal range 1..255.
REQ-004 SHALL have ports clk in 1 (clock) and reset in 1 (one clock; reset is asynchronous and active-low).
REQ-005 SHALL have ports req_valid in 1 (request present) and req_ready out 1 (request accepted when both are high at a clk edge).
REQ-006 SHALL have ports req_we in 1 (1=store, 0=load) and req_type in 3 (000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned, 101 dword).
REQ-007 SHALL have ports req_addr in ADDR_W (byte address) and req_wdata in DATA_W (store data, right-justified).
REQ-008 SHALL have ports resp_valid out 1, resp_rdata out DATA_W and resp_err out 1 (completion, extended load data, error flag).
REQ-009 SHALL have ports mem_en out 1, mem_addr out ADDR_W, mem_wdata out DATA_W and mem_wea out DATA_W/8 (memory request, bus-aligned address, lane-shifted data, byte write enables).
REQ-010 SHALL have ports mem_rdata in DATA_W, mem_ready in 1 (memory response) and busy out 1 (state is not IDLE).

Function
REQ-011 SHALL implement FSM states IDLE, ACCESS and RESP; req_ready SHALL equal (state==IDLE).
REQ-012 SHALL latch req_we, req_type, req_addr and req_wdata on acceptance; later input changes SHALL have no effect on the access.
REQ-013 SHALL compute size as byte=1, half=2, word=4, dword=8; misaligned SHALL mean addr mod size != 0.
REQ-014 SHALL treat dword with DATA_W=32, or req_type 110/111, as an error.
REQ-015 SHALL go IDLE->RESP with resp_err=1 on acceptance of a misaligned or illegal request, and SHALL NOT assert mem_en for it.
REQ-016 SHALL go IDLE->ACCESS on acceptance of a legal request and clear the wait counter to 0.
REQ-017 SHALL, in ACCESS, hold mem_en=1, with mem_addr = latched address with its low log2(DATA_W/8) bits zeroed.
REQ-018 SHALL, in ACCESS for stores, drive mem_wea with size consecutive ones starting at lane off = addr mod (DATA_W/8), and mem_wdata = req_wdata shifted left by 8*off; loads SHALL drive mem_wea=0.
REQ-019 SHALL, when mem_ready=1 at a clk edge in ACCESS, capture mem_rdata, go to RESP with resp_err=0, and keep mem_en=1 through that edge only.
REQ-020 SHALL extract load data as mem_rdata shifted right by 8*off, then sign-extend (word on 64-bit, half, byte) or zero-extend (half-unsigned, byte-unsigned) to DATA_W; word on 32-bit and dword SHALL pass through.
REQ-021 SHALL increment the wait counter each ACCESS cycle with mem_ready=0; reaching TIMEOUT SHALL go to RESP with resp_err=1.
REQ-022 SHALL give mem_ready priority over timeout when both occur at the same edge.
REQ-023 SHALL assert resp_valid for exactly one cycle in RESP and then return to IDLE; resp_rdata SHALL be 0 for stores and errors.
REQ-024 SHALL hold resp_rdata stable until the next RESP.
REQ-025 SHALL have a best-case latency of 2 cycles from acceptance edge to resp_valid high (mem_ready high in the first ACCESS cycle); back-to-back throughput SHALL be one access per 3 cycles.
REQ-026 SHALL ignore mem_ready outside ACCESS.
REQ-027 SHALL drive all outputs from registers or from state only, with no combinational path from req_* to mem_*.

Reset
REQ-028 SHALL, while reset=0, asynchronously force state IDLE, wait counter 0, and resp_valid, resp_err, mem_en, mem_wea, busy, resp_rdata, mem_addr and mem_wdata to 0; req_ready SHALL be 1.
REQ-029 SHALL abort an in-flight access on reset assertion, with no resp_valid for the aborted request.

Verification
REQ-030 DATA_W=32, load half at 0x102, mem_rdata=0x8001_1234 with ready in cycle 1 -> mem_addr=0x100, resp_rdata=0xFFFF_8001 two cycles after acceptance, resp_err=0.
REQ-031 Store byte 0xAB at 0x203 -> mem_wea=1000, mem_wdata=0xAB00_0000, mem_addr=0x200.
REQ-032 Load word at 0x101 -> resp_err=1 one cycle after acceptance, mem_en never high.
REQ-033 TIMEOUT=4, mem_ready held 0 -> mem_en high 4 cycles, then resp_valid=1, resp_err=1; second run with mem_ready=1 on the 4th cycle -> resp_err=0.
REQ-034 DATA_W=64, load byte-unsigned at 0x7 with mem_rdata=0xFE00...00 -> resp_rdata=0x0000_0000_0000_00FE; dword with DATA_W=32 -> resp_err=1.
REQ-035 reset=0 during ACCESS -> mem_en=0 immediately, no resp_valid, req_ready=1 after release.
